// File: rtl/actividad03_verificador_if.sv
// Stimulus, observation and status bundle between the actividad03 checker
// and the gate block it exercises.
interface actividad03_verificador_if #(
   parameter int ERR_W = 3
);
   logic             iniciar;
   logic             entrada1;
   logic             entrada2;
   logic             salidaand;
   logic             salidaor;
   logic             salidaxor;
   logic             salidanot;
   logic             salidanand;
   logic             salidayes;
   logic             salidanor;
   logic             salidaxnor;
   logic             ocupado;
   logic             terminado;
   logic             paso;
   logic [ERR_W-1:0] errores;
   logic [1:0]       vector_fallo;
   logic [7:0]       mascara_fallo;

   modport master (
      input  iniciar,
      input  salidaand, salidaor, salidaxor, salidanot,
      input  salidanand, salidayes, salidanor, salidaxnor,
      output entrada1, entrada2,
      output ocupado, terminado, paso,
      output errores, vector_fallo, mascara_fallo
   );

   modport slave (
      output iniciar,
      output salidaand, salidaor, salidaxor, salidanot,
      output salidanand, salidayes, salidanor, salidaxnor,
      input  entrada1, entrada2,
      input  ocupado, terminado, paso,
      input  errores, vector_fallo, mascara_fallo
   );
endinterface

// File: rtl/actividad03_verificador.sv
// On-board self-test for the actividad03 gate block: walks the four input
// vectors, compares the eight gate outputs and reports pass/fail.
module actividad03_verificador #(
   parameter int SETTLE_CYCLES = 4,
   parameter int ERR_W         = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   actividad03_verificador_if.master   bus
);

   localparam int                CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_FIN = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [ERR_W-1:0]  ERR_MAX = '1;

   typedef enum logic [1:0] {IDLE, ESPERA, COMPARAR, FIN} estado_t;

   estado_t          estado;
   estado_t          estado_sig;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic [7:0]       obs_p0;
   logic [7:0]       mism;
   logic             arranque;
   logic             muestrear;
   logic             comparar;
   logic             avanzar;
   logic             cerrar;

   // Bit order: [7]and [6]or [5]xor [4]not [3]nand [2]yes [1]nor [0]xnor
   function automatic logic [7:0] esperado(input logic a, input logic b);
      return {a & b, a | b, a ^ b, ~a, ~(a & b), a, ~(a | b), ~(a ^ b)};
   endfunction

   function automatic logic [ERR_W-1:0] sumar_sat(input logic [ERR_W-1:0] v);
      return (v == ERR_MAX) ? v : v + ERR_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) estado <= IDLE;
      else     estado <= estado_sig;
   end

   always_comb begin
      estado_sig = estado;
      unique case (estado)
         IDLE:     if (bus.iniciar) estado_sig = ESPERA;
         ESPERA:   if (cnt == CNT_FIN) estado_sig = COMPARAR;
         COMPARAR: estado_sig = (idx == 2'd3) ? FIN : ESPERA;
         FIN:      estado_sig = IDLE;
         default:  estado_sig = IDLE;
      endcase
   end

   always_comb begin
      arranque  = (estado == IDLE) && bus.iniciar;
      muestrear = (estado == ESPERA) && (cnt == CNT_FIN);
      comparar  = (estado == COMPARAR);
      avanzar   = comparar && (idx != 2'd3);
      cerrar    = (estado == FIN);
   end

   // Stage p0: DUV outputs captured at the end of the settle window
   always_ff @(posedge clk) begin
      if (muestrear)
         obs_p0 <= {bus.salidaand, bus.salidaor, bus.salidaxor, bus.salidanot,
                    bus.salidanand, bus.salidayes, bus.salidanor, bus.salidaxnor};
   end

   assign mism = obs_p0 ^ esperado(idx[1], idx[0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= '0;
      end else if (arranque) begin
         cnt <= '0;
         idx <= '0;
      end else if (avanzar) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else if (estado == ESPERA) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // errores never returns to zero within a run, so it doubles as the first-failure flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.entrada1      <= 1'b0;
         bus.entrada2      <= 1'b0;
         bus.ocupado       <= 1'b0;
         bus.terminado     <= 1'b0;
         bus.paso          <= 1'b0;
         bus.errores       <= '0;
         bus.vector_fallo  <= '0;
         bus.mascara_fallo <= '0;
      end else if (arranque) begin
         bus.entrada1      <= 1'b0;
         bus.entrada2      <= 1'b0;
         bus.ocupado       <= 1'b1;
         bus.terminado     <= 1'b0;
         bus.paso          <= 1'b0;
         bus.errores       <= '0;
         bus.vector_fallo  <= '0;
         bus.mascara_fallo <= '0;
      end else if (comparar) begin
         if (mism != 8'd0) begin
            bus.errores <= sumar_sat(bus.errores);
            if (bus.errores == '0) begin
               bus.vector_fallo  <= idx;
               bus.mascara_fallo <= mism;
            end
         end
         if (avanzar)
            {bus.entrada1, bus.entrada2} <= idx + 2'd1;
      end else if (cerrar) begin
         bus.terminado <= 1'b1;
         bus.paso      <= (bus.errores == '0);
         bus.ocupado   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_actividad03_verificador.sv
// Bench for actividad03_verificador: emulated gate block with stuck-at faults,
// fixed vector table, hand-written corner sequences and randomized faults.
module tb_actividad03_verificador;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ini = 1'b0;
   logic sel = 1'b0;
   logic [7:0] sa0_0 = 8'h00, sa1_0 = 8'h00, sa0_1 = 8'h00, sa1_1 = 8'h00;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   actividad03_verificador_if #(.ERR_W(3)) bus0 ();
   actividad03_verificador_if #(.ERR_W(1)) bus1 ();

   actividad03_verificador #(.SETTLE_CYCLES(4), .ERR_W(3)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   actividad03_verificador #(.SETTLE_CYCLES(1), .ERR_W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   function automatic logic [7:0] compuertas(input logic a, input logic b);
      logic [7:0] g;
      g[7] = a & b;   g[6] = a | b;    g[5] = a ^ b;    g[4] = !a;
      g[3] = !(a & b); g[2] = a;       g[1] = !(a | b); g[0] = (a == b);
      return g;
   endfunction

   assign bus0.iniciar = ini & ~sel;
   assign bus1.iniciar = ini & sel;
   assign {bus0.salidaand, bus0.salidaor, bus0.salidaxor, bus0.salidanot,
           bus0.salidanand, bus0.salidayes, bus0.salidanor, bus0.salidaxnor} =
          (compuertas(bus0.entrada1, bus0.entrada2) & ~sa0_0) | sa1_0;
   assign {bus1.salidaand, bus1.salidaor, bus1.salidaxor, bus1.salidanot,
           bus1.salidanand, bus1.salidayes, bus1.salidanor, bus1.salidaxnor} =
          (compuertas(bus1.entrada1, bus1.entrada2) & ~sa0_1) | sa1_1;

   logic [1:0] m_ent, m_vec;
   logic       m_ocup, m_term, m_paso;
   logic [2:0] m_err;
   logic [7:0] m_mask;

   always_comb begin
      if (sel) begin
         m_ent = {bus1.entrada1, bus1.entrada2}; m_ocup = bus1.ocupado; m_term = bus1.terminado;
         m_paso = bus1.paso; m_err = 3'(bus1.errores); m_vec = bus1.vector_fallo; m_mask = bus1.mascara_fallo;
      end else begin
         m_ent = {bus0.entrada1, bus0.entrada2}; m_ocup = bus0.ocupado; m_term = bus0.terminado;
         m_paso = bus0.paso; m_err = bus0.errores; m_vec = bus0.vector_fallo; m_mask = bus0.mascara_fallo;
      end
   end

   typedef struct {
      logic [7:0] sa0;
      logic [7:0] sa1;
      int         err;
      int         vec;
      int         mask;
      int         paso;
   } vector_t;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_fault(input logic [7:0] a0, input logic [7:0] a1);
      if (sel) begin sa0_1 = a0; sa1_1 = a1; end
      else     begin sa0_0 = a0; sa1_0 = a1; end
   endtask

   // Whole-run outcome from the gate rules: count failing vectors, clip, remember the first
   task automatic ref_run(input logic [7:0] a0, input logic [7:0] a1, input int errw,
                          output int err, output int vec, output int mask, output int paso);
      int fallos;
      logic [7:0] d;
      fallos = 0; vec = 0; mask = 0;
      for (int k = 0; k < 4; k++) begin
         d = ((compuertas(k[1], k[0]) & ~a0) | a1) ^ compuertas(k[1], k[0]);
         if (d != 8'd0) begin
            if (fallos == 0) begin vec = k; mask = int'(d); end
            fallos++;
         end
      end
      err  = (fallos > (1 << errw) - 1) ? (1 << errw) - 1 : fallos;
      paso = (fallos == 0) ? 1 : 0;
   endtask

   task automatic do_run(input string name, input int s, input bit hold,
                         input int e_err, input int e_vec, input int e_mask, input int e_paso);
      int lat, ix, t;
      bit seq_ok;
      lat = 4 * (s + 1) + 1;
      seq_ok = 1'b1;
      @(negedge clk); ini = 1'b1;
      @(posedge clk); #1;
      if (!hold) ini = 1'b0;
      for (int n = 0; n <= lat; n++) begin
         ix = n / (s + 1);
         if (ix > 3) ix = 3;
         if (m_ent !== ix[1:0]) seq_ok = 1'b0;
         if (m_term !== (n == lat)) seq_ok = 1'b0;
         if (m_ocup !== (n < lat)) seq_ok = 1'b0;
         if (n < lat) begin @(posedge clk); #1; end
      end
      check({name, "_secuencia"}, int'(seq_ok), 1);
      check({name, "_errores"}, int'(m_err), e_err);
      check({name, "_vector"}, int'(m_vec), e_vec);
      check({name, "_mascara"}, int'(m_mask), e_mask);
      check({name, "_paso"}, int'(m_paso), e_paso);
      check({name, "_ent_final"}, int'(m_ent), 3);
      if (hold) begin
         @(posedge clk); #1;
         check({name, "_reinicio_term"}, int'(m_term), 0);
         check({name, "_reinicio_ocup"}, int'(m_ocup), 1);
         check({name, "_reinicio_err"}, int'(m_err), 0);
         ini = 1'b0;
         t = 0;
         while (m_term !== 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
         check({name, "_reinicio_fin"}, int'(m_term), 1);
         check({name, "_reinicio_errores"}, int'(m_err), e_err);
      end
   endtask

   initial begin
      vector_t tabla [6];
      int r_err, r_vec, r_mask, r_paso;
      logic [7:0] a0, a1;

      tabla[0] = '{8'h00, 8'h00, 0, 0, 8'h00, 1};
      tabla[1] = '{8'h20, 8'h00, 2, 1, 8'h20, 0};
      tabla[2] = '{8'hFF, 8'h00, 4, 0, 8'h1B, 0};
      tabla[3] = '{8'h00, 8'h04, 2, 0, 8'h04, 0};
      tabla[4] = '{8'h00, 8'h02, 3, 1, 8'h02, 0};
      tabla[5] = '{8'h01, 8'h80, 4, 0, 8'h81, 0};

      #1;
      check("reset_ent0", int'({bus0.entrada1, bus0.entrada2}), 0);
      check("reset_status0", int'({bus0.ocupado, bus0.terminado, bus0.paso}), 0);
      check("reset_err0", int'(bus0.errores), 0);
      check("reset_status1", int'({bus1.ocupado, bus1.terminado, bus1.paso, bus1.errores}), 0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         set_fault(tabla[i].sa0, tabla[i].sa1);
         do_run($sformatf("tabla%0d", i), 4, 1'b0, tabla[i].err, tabla[i].vec, tabla[i].mask, tabla[i].paso);
      end

      set_fault(8'h00, 8'h00);
      do_run("mantenido", 4, 1'b1, 0, 0, 0, 1);

      // Asynchronous reset in the settle window of vector 2
      set_fault(8'hFF, 8'h00);
      @(negedge clk); ini = 1'b1;
      @(posedge clk); #1; ini = 1'b0;
      repeat (12) @(posedge clk);
      #3;
      check("pre_reset_ent", int'(m_ent), 2);
      check("pre_reset_err", int'(m_err), 2);
      rst = 1'b1;
      #1;
      check("reset_medio_ent", int'(m_ent), 0);
      check("reset_medio_status", int'({m_ocup, m_term, m_paso}), 0);
      check("reset_medio_err", int'(m_err), 0);
      check("reset_medio_fallo", int'({m_vec, m_mask}), 0);
      @(negedge clk); rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_idle", int'({m_ocup, m_term, m_ent}), 0);
      set_fault(8'h00, 8'h00);
      do_run("post_reset", 4, 1'b0, 0, 0, 0, 1);

      for (int i = 0; i < 6; i++) begin
         a0 = 8'($urandom) & 8'($urandom);
         a1 = 8'($urandom) & 8'($urandom) & 8'($urandom);
         set_fault(a0, a1);
         ref_run(a0, a1, 3, r_err, r_vec, r_mask, r_paso);
         do_run($sformatf("aleat%0d", i), 4, 1'b0, r_err, r_vec, r_mask, r_paso);
      end

      sel = 1'b1;
      set_fault(8'h00, 8'h00);
      do_run("s1_bueno", 1, 1'b0, 0, 0, 0, 1);
      set_fault(8'hFF, 8'h00);
      do_run("s1_saturado", 1, 1'b0, 1, 0, 8'h1B, 0);
      for (int i = 0; i < 3; i++) begin
         a0 = 8'($urandom) & 8'($urandom);
         a1 = 8'($urandom) & 8'($urandom) & 8'($urandom);
         set_fault(a0, a1);
         ref_run(a0, a1, 1, r_err, r_vec, r_mask, r_paso);
         do_run($sformatf("s1_aleat%0d", i), 1, 1'b0, r_err, r_vec, r_mask, r_paso);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
